// File: rtl/hmac_tag_strip.sv
// rtl/hmac_tag_strip.sv - strips the trailing HMAC tag beat off a stream packet
// Optional statistics counters are enabled with `define HMAC_TAG_STRIP_STATS_EN.
module hmac_tag_strip #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int ID_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inp_data,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic [DATA_W-1:0] tag_data,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [KEEP_W-1:0] tag_keep,
  output logic [ID_W-1:0]   tag_id,
  output logic              tag_short
`ifdef HMAC_TAG_STRIP_STATS_EN
  ,
  output logic [31:0]       pkt_count,
  output logic [31:0]       short_count
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_FLUSH} state_t;

  state_t            state, state_nxt;
  logic              out_pend, out_pend_nxt;
  logic              tag_pend, tag_pend_nxt;
  logic              hold_load, tag_load, tag_load_short;

  logic [DATA_W-1:0] hold_data, tagr_data;
  logic [KEEP_W-1:0] hold_keep, tagr_keep;
  logic [ID_W-1:0]   hold_id, tagr_id;
  logic              tagr_short;

  // State and pending-bit registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_EMPTY;
      out_pend <= 1'b0;
      tag_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_pend <= out_pend_nxt;
      tag_pend <= tag_pend_nxt;
    end
  end

  // Next-state and handshake decode; the held beat is only released once its
  // successor shows up, so the final payload beat can be re-marked as last.
  always_comb begin
    state_nxt      = state;
    out_pend_nxt   = out_pend;
    tag_pend_nxt   = tag_pend;
    inp_ready      = 1'b0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    tag_valid      = 1'b0;
    hold_load      = 1'b0;
    tag_load       = 1'b0;
    tag_load_short = 1'b0;
    case (state)
      S_EMPTY: begin
        inp_ready = 1'b1;
        if (inp_valid) begin
          if (inp_last) begin
            tag_load       = 1'b1;
            tag_load_short = 1'b1;
            out_pend_nxt   = 1'b0;
            tag_pend_nxt   = 1'b1;
            state_nxt      = S_FLUSH;
          end else begin
            hold_load = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inp_valid && inp_last) begin
          inp_ready    = 1'b1;
          tag_load     = 1'b1;
          out_pend_nxt = 1'b1;
          tag_pend_nxt = 1'b1;
          state_nxt    = S_FLUSH;
        end else begin
          out_valid = inp_valid;
          inp_ready = out_ready;
          hold_load = inp_valid && out_ready;
        end
      end
      S_FLUSH: begin
        out_valid = out_pend;
        out_last  = out_pend;
        tag_valid = tag_pend;
        if (out_pend && out_ready) out_pend_nxt = 1'b0;
        if (tag_pend && tag_ready) tag_pend_nxt = 1'b0;
        if (!out_pend_nxt && !tag_pend_nxt) state_nxt = S_EMPTY;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Beat registers: hold carries the newest unreleased payload beat, tagr the tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_id    <= '0;
      tagr_data  <= '0;
      tagr_keep  <= '0;
      tagr_id    <= '0;
      tagr_short <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_data <= inp_data;
        hold_keep <= inp_keep;
        hold_id   <= inp_id;
      end
      if (tag_load) begin
        tagr_data  <= inp_data;
        tagr_keep  <= inp_keep;
        tagr_id    <= inp_id;
        tagr_short <= tag_load_short;
      end
    end
  end

  assign out_data  = hold_data;
  assign out_keep  = hold_keep;
  assign out_id    = hold_id;
  assign tag_data  = tagr_data;
  assign tag_keep  = tagr_keep;
  assign tag_id    = tagr_id;
  assign tag_short = tagr_short;

`ifdef HMAC_TAG_STRIP_STATS_EN
  // Packet and short-packet counters, advanced on each tag handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_count   <= '0;
      short_count <= '0;
    end else if (tag_valid && tag_ready) begin
      pkt_count <= pkt_count + 32'd1;
      if (tagr_short) short_count <= short_count + 32'd1;
    end
  end
`endif

endmodule
